// File: rtl/termcon.sv
// rtl/termcon.sv - character-to-terminal write sequencer with cursor tracking (optional form-feed clear: TERMCON_FF_CLEAR_EN)
`timescale 1ns/1ps
module termcon #(
  parameter int COLS = 80,
  parameter int ROWS = 30
) (
  input  logic       cpuclk,
  input  logic       n_rst,
  input  logic [7:0] chin,
  input  logic       chvalid,
  output logic       chready,
  input  logic       termbusy,
  output logic [1:0] addrout,
  output logic [7:0] dataout,
  output logic       outen,
  output logic [6:0] col,
  output logic [4:0] row
);

  localparam logic [6:0] COL_MAX = 7'(COLS - 1);
  localparam logic [4:0] ROW_MAX = 5'(ROWS - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SETX = 3'd1,
    SETY = 3'd2,
    PUT  = 3'd3,
    WAIT = 3'd4
`ifdef TERMCON_FF_CLEAR_EN
    , CLR  = 3'd5
`endif
  } state_t;

  state_t     state, state_nxt, after;
  logic [7:0] chr;
  logic [6:0] wx;
  logic [4:0] wy;
  logic [7:0] wd;

`ifdef TERMCON_FF_CLEAR_EN
  logic       clearing;
  logic [6:0] cx;
  logic [4:0] cy;

  // During a clear the write target walks the screen instead of the cursor
  always_comb begin
    wx = col;
    wy = row;
    wd = chr;
    if (clearing) begin
      wx = cx;
      wy = cy;
      wd = 8'h20;
    end
  end
`else
  // Write target is always the cursor position and the latched byte
  always_comb begin
    wx = col;
    wy = row;
    wd = chr;
  end
`endif

  // State register
  always_ff @(posedge cpuclk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and terminal strobe; each write waits for termbusy low
  always_comb begin
    state_nxt = state;
    chready   = 1'b0;
    outen     = 1'b0;
    addrout   = 2'd0;
    dataout   = 8'd0;
    case (state)
      IDLE: begin
        chready = 1'b1;
        if (chvalid) begin
          if (chin >= 8'h20 && chin <= 8'h7E) state_nxt = SETX;
`ifdef TERMCON_FF_CLEAR_EN
          else if (chin == 8'h0C) state_nxt = CLR;
`endif
        end
      end
      SETX: begin
        addrout = 2'd1;
        dataout = {1'b0, wx};
        if (!termbusy) begin
          outen     = 1'b1;
          state_nxt = WAIT;
        end
      end
      SETY: begin
        addrout = 2'd2;
        dataout = {3'b000, wy};
        if (!termbusy) begin
          outen     = 1'b1;
          state_nxt = WAIT;
        end
      end
      PUT: begin
        addrout = 2'd0;
        dataout = wd;
        if (!termbusy) begin
          outen     = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: state_nxt = after;
`ifdef TERMCON_FF_CLEAR_EN
      CLR:  state_nxt = SETX;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Byte latch, post-WAIT target and cursor/clear position bookkeeping
  always_ff @(posedge cpuclk or negedge n_rst) begin
    if (!n_rst) begin
      after <= IDLE;
      chr   <= 8'd0;
      col   <= 7'd0;
      row   <= 5'd0;
`ifdef TERMCON_FF_CLEAR_EN
      clearing <= 1'b0;
      cx       <= 7'd0;
      cy       <= 5'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (chvalid) begin
            chr <= chin;
            case (chin)
              8'h0A: begin
                col <= 7'd0;
                row <= (row == ROW_MAX) ? 5'd0 : row + 5'd1;
              end
              8'h0D: col <= 7'd0;
              8'h08: if (col != 7'd0) col <= col - 7'd1;
              default: ;
            endcase
          end
        end
        SETX: after <= SETY;
        SETY: after <= PUT;
        PUT: begin
          if (!termbusy) begin
`ifdef TERMCON_FF_CLEAR_EN
            if (clearing) begin
              if (cx == COL_MAX && cy == ROW_MAX) begin
                clearing <= 1'b0;
                col      <= 7'd0;
                row      <= 5'd0;
                after    <= IDLE;
              end else begin
                after <= SETX;
                if (cx == COL_MAX) begin
                  cx <= 7'd0;
                  cy <= cy + 5'd1;
                end else begin
                  cx <= cx + 7'd1;
                end
              end
            end else begin
`endif
              after <= IDLE;
              if (col == COL_MAX) begin
                col <= 7'd0;
                row <= (row == ROW_MAX) ? 5'd0 : row + 5'd1;
              end else begin
                col <= col + 7'd1;
              end
`ifdef TERMCON_FF_CLEAR_EN
            end
`endif
          end
        end
`ifdef TERMCON_FF_CLEAR_EN
        CLR: begin
          clearing <= 1'b1;
          cx       <= 7'd0;
          cy       <= 5'd0;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: doc/termcon.md
TERMCON -- requirements
Module: termcon

Interface
REQ-001 SHALL have parameter COLS, default 80, text columns (1..128).
REQ-002 SHALL have parameter ROWS, default 30, text rows (1..32).
REQ-003 SHALL have port cpuclk  input  1  CPU-side clock; all state on its rising edge.
REQ-004 SHALL have port n_rst  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port chin  input  8  character byte from CPU.
REQ-006 SHALL have port chvalid  input  1  chin valid.
REQ-007 SHALL have port chready  output  1  block can accept a byte.
REQ-008 SHALL have port termbusy  input  1  terminal busy flag (term busy).
REQ-009 SHALL have port addrout  output  2  terminal register select: 0 OUT, 1 X, 2 Y, 3 ATTR.
REQ-010 SHALL have port dataout  output  8  terminal register data.
REQ-011 SHALL have port outen  output  1  terminal write strobe, one cycle per write.
REQ-012 SHALL have port col  output  7  current cursor column.
REQ-013 SHALL have port row  output  5  current cursor row.

Function
REQ-014 SHALL run the FSM states IDLE, SETX, SETY, PUT, WAIT, CLR; chready SHALL be 1 only in IDLE.
REQ-015 SHALL accept a byte on the rising edge where chvalid=1 and chready=1; the byte is latched and chin is ignored until the next IDLE.
REQ-016 Printable bytes 0x20..0x7E SHALL issue the write sequence X=col, then Y=row, then OUT=byte.
REQ-017 Each write SHALL be issued in its state only when termbusy=0; outen is high for exactly that one cycle with addrout/dataout valid; otherwise the block SHALL hold the state with outen=0.
REQ-018 After every write the FSM SHALL spend one WAIT cycle, then proceed to the next write or to IDLE.
REQ-019 With termbusy=0 throughout, a printable byte accepted at edge 0 SHALL produce strobes in cycles 1 (X), 3 (Y) and 5 (OUT), with chready=1 again in cycle 7.
REQ-020 On the OUT write, col SHALL increment; col=COLS-1 SHALL wrap to 0 with row+1; row=ROWS-1 SHALL wrap to 0.
REQ-021 0x0A (LF) SHALL set col=0 and row=row+1 (wrapping to 0 at ROWS), with no terminal write; the block returns to IDLE in 1 cycle.
REQ-022 0x0D (CR) SHALL set col=0, with no write.
REQ-023 0x08 (BS) SHALL decrement col if col>0; at col=0 it SHALL do nothing, with no write.
REQ-024 All other bytes SHALL be discarded with no write and no cursor change.
REQ-025 col/row SHALL only change in the cycles stated above; termbusy never alters cursor state.
REQ-026 The block SHALL never write the ATTR register (addrout=3).

Reset
REQ-027 n_rst=0 SHALL immediately force state IDLE, outen=0, addrout=0, dataout=0, col=0, row=0, and chready=1.
REQ-028 Reset asserted mid-sequence SHALL abort it without completing the pending writes; the next byte starts a fresh sequence.

Configuration
REQ-029 With macro TERMCON_FF_CLEAR_EN defined, 0x0C (FF) SHALL enter CLR, which writes 0x20 to every cell row-major from (0,0) to (COLS-1,ROWS-1), each cell using the X/Y/OUT sequence and the busy rules of REQ-017/REQ-018.
REQ-030 At the end of CLR the block SHALL set col=0 and row=0 and return to IDLE; chready SHALL stay 0 for the whole clear.
REQ-031 Without TERMCON_FF_CLEAR_EN, 0x0C SHALL be discarded as in REQ-024, and no CLR logic SHALL be synthesised.

Verification
REQ-032 Reset, then send 'A' (0x41) with termbusy=0 -> strobes (addr,data) (1,0x00), (2,0x00), (0,0x41) in cycles 1, 3 and 5; col=1; chready=1 in cycle 7.
REQ-033 Hold termbusy=1 for 10 cycles after acceptance -> no outen; the X write occurs in the first cycle after termbusy falls.
REQ-034 At col=79, row=29, send 'Z' -> OUT write with X=79, Y=29; then col=0, row=0.
REQ-035 Send 'A', 0x08, 0x08, 0x0D, 0x0A, 0x07 -> col 1, 0, 0, 0, then row+1, col 0; total outen count 3.
REQ-036 Assert n_rst after the Y strobe of a printable -> no OUT strobe; col=0, row=0, chready=1.
REQ-037 With TERMCON_FF_CLEAR_EN, send 0x0C -> 7200 strobes, 2400 of them OUT=0x20, the last at X=79, Y=29; then col=0, row=0. Without the macro -> zero strobes.
